// File: rtl/uart_frame_parser.sv
// uart_frame_parser: turns a UART byte stream of [A5, LEN, LEN x 16-bit samples, CHK]
// frames into a sample FIFO. Samples are written speculatively and become visible only
// once the frame checksum matches; bad frames are rolled back out of the FIFO.
// Optional build macro UART_FRAME_TIMEOUT_EN adds an inter-byte idle timeout.
module uart_frame_parser #(
    parameter int FIFO_DEPTH     = 64,
    parameter int MAX_LEN        = 32,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        frame_done,
    output logic        frame_error,
    output logic [2:0]  err_code
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [7:0] SYNC = 8'hA5;

    // Catch illegal parameter sets at elaboration.
    if (FIFO_DEPTH < MAX_LEN || MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1 ||
        FIFO_DEPTH != (1 << AW)) begin : g_bad_param
        $error("uart_frame_parser: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_HUNT, S_LEN, S_DATA_HI, S_DATA_LO, S_CHECK, S_SKIP
    } state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_len, r_cnt, r_chk, r_hi;
    logic [8:0]      r_skip;
    logic [15:0]     r_sample;
    logic            r_wr_pend;
    logic [PW-1:0]   r_wr_ptr, r_cm_ptr, r_rd_ptr;
    logic [15:0]     r_mem [FIFO_DEPTH];
    logic            r_done, r_error;
    logic [2:0]      r_err_code;

    logic [PW-1:0]   w_wr_eff, w_used, w_free;
    logic            w_len_bad, w_no_space, w_pop, w_timeout, w_byte;
    logic            w_done, w_fail, w_commit, w_rollback, w_push;
    logic [2:0]      w_fail_code;

    // A sample assembled last cycle is still pending its FIFO write; count it as written.
    assign w_wr_eff   = r_wr_ptr + PW'(r_wr_pend);
    assign w_used     = w_wr_eff - r_rd_ptr;
    assign w_free     = PW'(FIFO_DEPTH) - w_used;
    assign w_len_bad  = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
    assign w_no_space = 16'(rx_data) > 16'(w_free);
    assign w_pop      = sample_valid & sample_ready;
    assign w_byte     = rx_valid & ~w_timeout;

    assign sample_valid = (r_cm_ptr != r_rd_ptr);
    assign sample_out   = r_mem[r_rd_ptr[AW-1:0]];
    assign frame_done   = r_done;
    assign frame_error  = r_error;
    assign err_code     = r_err_code;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_idle;

    assign w_timeout = (r_state != S_HUNT) && (r_idle == TW'(TIMEOUT_CYCLES));

    // Idle counter: runs only inside a frame, restarts on every received byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_idle <= '0;
        else if (r_state == S_HUNT || rx_valid || w_timeout)
            r_idle <= '0;
        else
            r_idle <= r_idle + TW'(1);
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_HUNT;
        else          r_state <= w_next;
    end

    // Next-state decode plus the per-byte control strobes.
    always_comb begin
        w_next      = r_state;
        w_done      = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = 3'd0;
        w_commit    = 1'b0;
        w_rollback  = 1'b0;
        w_push      = 1'b0;
        if (w_timeout) begin
            w_next      = S_HUNT;
            w_rollback  = 1'b1;
            w_fail      = 1'b1;
            w_fail_code = 3'd4;
        end else if (rx_valid) begin
            case (r_state)
                S_HUNT:    if (rx_data == SYNC) w_next = S_LEN;
                S_LEN: begin
                    if (w_len_bad) begin
                        w_next      = S_HUNT;
                        w_fail      = 1'b1;
                        w_fail_code = 3'd1;
                    end else if (w_no_space) begin
                        w_next      = S_SKIP;
                        w_fail      = 1'b1;
                        w_fail_code = 3'd3;
                    end else begin
                        w_next = S_DATA_HI;
                    end
                end
                S_DATA_HI: w_next = S_DATA_LO;
                S_DATA_LO: begin
                    w_push = 1'b1;
                    w_next = (r_cnt + 8'd1 == r_len) ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    w_next = S_HUNT;
                    if (rx_data == r_chk) begin
                        w_commit = 1'b1;
                        w_done   = 1'b1;
                    end else begin
                        w_rollback  = 1'b1;
                        w_fail      = 1'b1;
                        w_fail_code = 3'd2;
                    end
                end
                S_SKIP:    if (r_skip == 9'd1) w_next = S_HUNT;
                default:   w_next = S_HUNT;
            endcase
        end
    end

    // Frame bookkeeping: length, sample count, skip count, running checksum, byte assembly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len    <= '0;
            r_cnt    <= '0;
            r_skip   <= '0;
            r_chk    <= '0;
            r_hi     <= '0;
            r_sample <= '0;
        end else if (w_byte) begin
            case (r_state)
                S_LEN: begin
                    r_len  <= rx_data;
                    r_chk  <= rx_data;
                    r_cnt  <= '0;
                    r_skip <= {rx_data, 1'b1};
                end
                S_DATA_HI: begin
                    r_hi  <= rx_data;
                    r_chk <= r_chk ^ rx_data;
                end
                S_DATA_LO: begin
                    r_sample <= {r_hi, rx_data};
                    r_chk    <= r_chk ^ rx_data;
                    r_cnt    <= r_cnt + 8'd1;
                end
                S_SKIP:  r_skip <= r_skip - 9'd1;
                default: ;
            endcase
        end
    end

    // FIFO pointers: speculative write, commit fence, read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_pend <= 1'b0;
            r_wr_ptr  <= '0;
            r_cm_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            r_wr_pend <= w_push;
            r_wr_ptr  <= w_rollback ? r_cm_ptr : w_wr_eff;
            if (w_commit) r_cm_ptr <= w_wr_eff;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Sample storage; a write landing beyond a rollback is harmless since it is never exposed.
    always_ff @(posedge clk) begin
        if (r_wr_pend) r_mem[r_wr_ptr[AW-1:0]] <= r_sample;
    end

    // Registered status pulses and sticky error cause.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 3'd0;
        end else begin
            r_done  <= w_done;
            r_error <= w_fail;
            if (w_fail) r_err_code <= w_fail_code;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames plus randomized traffic,
// checked against a frame-level model (expected sample queue, expected pulse counts).
module tb_uart_frame_parser;

    localparam int DEPTH = 64;
    localparam int MAXL  = 32;
    localparam int TO    = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        sample_ready = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        frame_done;
    logic        frame_error;
    logic [2:0]  err_code;

    uart_frame_parser #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .frame_done(frame_done), .frame_error(frame_error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_bad = 0;
    int          n_done = 0, n_err = 0, exp_done = 0, exp_err = 0;
    logic [2:0]  exp_code = 3'd0;
    logic [15:0] exp_q[$];
    logic [15:0] pl[256];
    bit          rnd_rdy = 1'b0, hold_rdy = 1'b0;
    int          gap_max = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pulse counting and popped-sample checking against the model queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_done)  n_done++;
            if (frame_error) n_err++;
            if (frame_done || frame_error)
                chk("done_err_excl", 32'(frame_done & frame_error), 32'd0);
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 32'(sample_valid), 32'd0);
                else                   chk("sample", 32'(sample_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (rnd_rdy) sample_ready = hold_rdy ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (gap_max > 0) idle($urandom_range(0, gap_max));
        tick();
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    // Sends one frame and updates the model from the framing rules.
    task automatic do_frame(input int len, input bit bad, input bit rnd_pl);
        logic [7:0] c;
        int         free_slots;
        hold_rdy = 1'b1;
        send_byte(8'hA5);
        free_slots = DEPTH - exp_q.size();
        send_byte(8'(len));
        hold_rdy = 1'b0;
        if (len == 0 || len > MAXL) begin
            exp_err++;
            exp_code = 3'd1;
        end else if (free_slots < len) begin
            exp_err++;
            exp_code = 3'd3;
            send_byte(8'hA5);
            for (int i = 1; i < 2 * len + 1; i++) send_byte(8'($urandom));
        end else begin
            c = 8'(len);
            for (int i = 0; i < len; i++) begin
                if (rnd_pl) pl[i] = 16'($urandom);
                send_byte(pl[i][15:8]);
                send_byte(pl[i][7:0]);
                c = c ^ pl[i][15:8] ^ pl[i][7:0];
            end
            send_byte(bad ? (c ^ 8'h01) : c);
            if (bad) begin
                exp_err++;
                exp_code = 3'd2;
            end else begin
                exp_done++;
                for (int i = 0; i < len; i++) exp_q.push_back(pl[i]);
            end
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_done"}, 32'(n_done), 32'(exp_done));
        chk({tag, "_err"},  32'(n_err),  32'(exp_err));
        chk({tag, "_code"}, 32'(err_code), 32'(exp_code));
    endtask

    task automatic end_frame(input string tag);
        tick();
        idle(3);
        check_counts(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
        idle(2);
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
    endtask

    initial begin
        // Reset state.
        idle(3);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_done",  32'(frame_done),   32'd0);
        chk("rst_error", 32'(frame_error),  32'd0);
        chk("rst_code",  32'(err_code),     32'd0);
        reset_n = 1'b1;
        idle(2);

        // Good frame.
        sample_ready = 1'b1;
        pl[0] = 16'h1234; pl[1] = 16'h5678;
        do_frame(2, 1'b0, 1'b0);
        end_frame("good");
        drain("good");

        // Bad checksum, then the same frame intact.
        do_frame(2, 1'b1, 1'b0);
        end_frame("badchk");
        chk("badchk_valid", 32'(sample_valid), 32'd0);
        do_frame(2, 1'b0, 1'b0);
        end_frame("after_badchk");
        drain("after_badchk");

        // Bad lengths.
        do_frame(0, 1'b0, 1'b1);
        end_frame("len0");
        do_frame(MAXL + 1, 1'b0, 1'b1);
        end_frame("len_big");
        pl[0] = 16'hBEEF;
        do_frame(1, 1'b0, 1'b0);
        end_frame("after_badlen");
        drain("after_badlen");

        // No space: 62 committed entries, LEN=3 skipped, then a 1-sample frame.
        sample_ready = 1'b0;
        do_frame(31, 1'b0, 1'b1);
        end_frame("fill1");
        do_frame(31, 1'b0, 1'b1);
        end_frame("fill2");
        chk("full_valid", 32'(sample_valid), 32'd1);
        do_frame(3, 1'b0, 1'b1);
        end_frame("nospace");
        sample_ready = 1'b1;
        pl[0] = 16'hABCD;
        do_frame(1, 1'b0, 1'b0);
        end_frame("after_nospace");
        drain("nospace");

`ifdef UART_FRAME_TIMEOUT_EN
        // Timeout: stall mid-frame.
        begin
            int e0;
            e0 = n_err;
            send_byte(8'hA5);
            send_byte(8'h02);
            send_byte(8'h12);
            tick();
            for (int i = 0; i < 150 && n_err == e0; i++) tick();
            idle(2);
            exp_err++;
            exp_code = 3'd4;
            check_counts("timeout");
            chk("timeout_valid", 32'(sample_valid), 32'd0);
            pl[0] = 16'h1234; pl[1] = 16'h5678;
            do_frame(2, 1'b0, 1'b0);
            end_frame("after_timeout");
            drain("after_timeout");
        end
`endif

        // Back-to-back frames with continuous pop: commit and pop overlap.
        sample_ready = 1'b1;
        gap_max = 0;
        for (int f = 0; f < 10; f++) do_frame($urandom_range(1, 6), 1'b0, 1'b1);
        tick();
        idle(4);
        check_counts("b2b");
        drain("b2b");

        // Randomized traffic: random gaps, random consumer, occasional bad frames.
        rnd_rdy = 1'b1;
        gap_max = 3;
        for (int f = 0; f < 40; f++) begin
            int sel, len;
            sel = $urandom_range(0, 9);
            len = (sel == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXL + 1, MAXL + 8))
                             : $urandom_range(1, MAXL);
            do_frame(len, ($urandom_range(0, 4) == 0), 1'b1);
            end_frame("rnd");
        end
        rnd_rdy = 1'b0;
        gap_max = 0;
        sample_ready = 1'b1;
        drain("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
